// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types: controller state encoding used by the lap controller and display logic.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        SW_IDLE  = 2'd0,
        SW_RUN   = 2'd1,
        SW_PAUSE = 2'd2
    } sw_state_e;

    function automatic sw_state_e sw_toggle_next(input sw_state_e s);
        case (s)
            SW_IDLE:  return SW_RUN;
            SW_RUN:   return SW_PAUSE;
            SW_PAUSE: return SW_RUN;
            default:  return SW_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/lap_fifo.sv
// First-word fall-through lap FIFO; push visible at head one cycle later, flush wins over push/pop.
// Backpressure: a push while full is accepted only if a pop happens in the same cycle.
module lap_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic [AW:0]      level_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o    = (level_q == '0);
    assign full_o     = (level_q == FULL_LVL);
    assign head_dat_o = mem_q[rd_ptr_q];
    assign level_o    = level_q;

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        level_d = level_q;
        if (flush_i) begin
            level_d = '0;
        end else if (do_push && !do_pop) begin
            level_d = level_q + LVL_ONE;
        end else if (do_pop && !do_push) begin
            level_d = level_q - LVL_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            level_q <= level_d;
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (do_push) begin
                    mem_q[wr_ptr_q] <= push_dat_i;
                    wr_ptr_q        <= wr_ptr_q + PTR_ONE;
                end
                if (do_pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_ONE;
                end
            end
        end
    end

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch button controller: start/stop/clear FSM, wrapping counter and lap capture FIFO.
// Button effects land on the sampling edge; laps drain over valid/ready, overflow is sticky.
module stopwatch_lap_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MAX        = 99,
    parameter int LAP_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         tick,
    input  logic                         btn_toggle,
    input  logic                         btn_clear,
    input  logic                         btn_lap,
    output logic [DATA_WIDTH-1:0]        count,
    output logic                         running,
    output logic                         wrap,
    output logic                         lap_valid,
    input  logic                         lap_ready,
    output logic [DATA_WIDTH-1:0]        lap_data,
    output logic [$clog2(LAP_DEPTH):0]   lap_level,
    output logic                         lap_overflow
);

    localparam logic [DATA_WIDTH-1:0] MAX_C   = DATA_WIDTH'(MAX);
    localparam logic [DATA_WIDTH-1:0] CNT_ONE = DATA_WIDTH'(1);

    sw_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic                  wrap_q, wrap_d;
    logic                  running_q, running_d;
    logic                  ovf_q, ovf_d;
    logic                  inc;
    logic                  lap_push;
    logic                  lap_pop;
    logic                  fifo_full;
    logic                  fifo_empty;

    // A toggle in the same cycle suppresses the increment, so stop freezes the shown value.
    assign inc      = (state_q == SW_RUN) && tick && !btn_toggle && !btn_clear;
    assign lap_push = btn_lap && !btn_clear && (state_q != SW_IDLE);
    assign lap_pop  = lap_valid && lap_ready;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        if (btn_clear) begin
            state_d = SW_IDLE;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            if (btn_toggle) begin
                state_d = sw_toggle_next(state_q);
            end
            if (inc) begin
                if (count_q == MAX_C) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            if (lap_push && fifo_full && !lap_pop) begin
                ovf_d = 1'b1;
            end
        end
        running_d = (state_d == SW_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= SW_IDLE;
            count_q   <= '0;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wrap_q    <= wrap_d;
            running_q <= running_d;
            ovf_q     <= ovf_d;
        end
    end

    lap_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (LAP_DEPTH)
    ) u_lap_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (btn_clear),
        .push_i     (lap_push),
        .push_dat_i (count_q),
        .pop_i      (lap_pop),
        .head_dat_o (lap_data),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (lap_level)
    );

    assign count        = count_q;
    assign running      = running_q;
    assign wrap         = wrap_q;
    assign lap_valid    = !fifo_empty;
    assign lap_overflow = ovf_q;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Directed bench for the stopwatch lap controller; expected values are hand-computed constants.
module tb_stopwatch_lap_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic        btn_toggle;
    logic        btn_clear;
    logic        btn_lap;
    logic [15:0] count;
    logic        running;
    logic        wrap;
    logic        lap_valid;
    logic        lap_ready;
    logic [15:0] lap_data;
    logic [2:0]  lap_level;
    logic        lap_overflow;

    int checks = 0;
    int errors = 0;

    stopwatch_lap_ctrl #(.DATA_WIDTH(16), .MAX(99), .LAP_DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .btn_toggle   (btn_toggle),
        .btn_clear    (btn_clear),
        .btn_lap      (btn_lap),
        .count        (count),
        .running      (running),
        .wrap         (wrap),
        .lap_valid    (lap_valid),
        .lap_ready    (lap_ready),
        .lap_data     (lap_data),
        .lap_level    (lap_level),
        .lap_overflow (lap_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; tick = 1'b1; btn_toggle = 1'b0; btn_clear = 1'b0;
        btn_lap = 1'b0; lap_ready = 1'b0;
        #12;
        checks++; if (count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", running); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
        checks++; if (lap_valid !== 1'b0) begin errors++; $display("FAIL reset_lap_valid: got %b expected 0", lap_valid); end
        checks++; if (lap_level !== 3'd0) begin errors++; $display("FAIL reset_lap_level: got %0d expected 0", lap_level); end
        checks++; if (lap_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", lap_overflow); end
        @(posedge clk); #1;
        reset = 1'b0;
        step();
        checks++; if (count !== 16'd0 || running !== 1'b0) begin errors++; $display("FAIL idle_hold: got count=%0d running=%b expected 0/0", count, running); end
    endtask

    task automatic test_run_pause();
        btn_toggle = 1'b1; step(); btn_toggle = 1'b0;
        checks++; if (running !== 1'b1 || count !== 16'd0) begin errors++; $display("FAIL start: got running=%b count=%0d expected 1/0", running, count); end
        for (int k = 1; k <= 9; k++) begin
            step();
            checks++; if (count !== 16'(k)) begin errors++; $display("FAIL run_step: got %0d expected %0d", count, k); end
        end
        btn_toggle = 1'b1; step(); btn_toggle = 1'b0;
        checks++; if (running !== 1'b0 || count !== 16'd9) begin errors++; $display("FAIL stop: got running=%b count=%0d expected 0/9", running, count); end
        step(); step();
        checks++; if (count !== 16'd9) begin errors++; $display("FAIL pause_hold: got %0d expected 9", count); end
        btn_toggle = 1'b1; step(); btn_toggle = 1'b0;
        checks++; if (running !== 1'b1 || count !== 16'd9) begin errors++; $display("FAIL resume: got running=%b count=%0d expected 1/9", running, count); end
        step();
        checks++; if (count !== 16'd10) begin errors++; $display("FAIL resume_10: got %0d expected 10", count); end
        step();
        checks++; if (count !== 16'd11) begin errors++; $display("FAIL resume_11: got %0d expected 11", count); end
    endtask

    task automatic test_wrap();
        int bad = 0;
        for (int i = 12; i <= 98; i++) begin
            step();
            if (count !== 16'(i) || wrap !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL climb_to_98: got %0d bad cycles expected 0 (count now %0d)", bad, count); end
        step();
        checks++; if (count !== 16'd99 || wrap !== 1'b0) begin errors++; $display("FAIL at_max: got count=%0d wrap=%b expected 99/0", count, wrap); end
        step();
        checks++; if (count !== 16'd0 || wrap !== 1'b1) begin errors++; $display("FAIL wrap_edge: got count=%0d wrap=%b expected 0/1", count, wrap); end
        step();
        checks++; if (count !== 16'd1 || wrap !== 1'b0) begin errors++; $display("FAIL after_wrap: got count=%0d wrap=%b expected 1/0", count, wrap); end
    endtask

    task automatic test_clear_toggle();
        lap_ready = 1'b0;
        btn_lap = 1'b1;
        repeat (5) step();
        btn_lap = 1'b0;
        checks++; if (lap_level !== 3'd4 || lap_overflow !== 1'b1) begin errors++; $display("FAIL prefill: got level=%0d ovf=%b expected 4/1", lap_level, lap_overflow); end
        btn_toggle = 1'b1; btn_clear = 1'b1; btn_lap = 1'b1;
        step();
        btn_toggle = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
        checks++; if (count !== 16'd0 || running !== 1'b0) begin errors++; $display("FAIL clear_state: got count=%0d running=%b expected 0/0", count, running); end
        checks++; if (lap_level !== 3'd0 || lap_valid !== 1'b0 || lap_overflow !== 1'b0) begin errors++; $display("FAIL clear_fifo: got level=%0d valid=%b ovf=%b expected 0/0/0", lap_level, lap_valid, lap_overflow); end
        step();
        checks++; if (count !== 16'd0 || running !== 1'b0) begin errors++; $display("FAIL clear_idle: got count=%0d running=%b expected 0/0", count, running); end
    endtask

    task automatic test_lap_fifo();
        logic [15:0] exp_a [4] = '{16'd3, 16'd5, 16'd7, 16'd9};
        logic [15:0] exp_b [4] = '{16'd2, 16'd3, 16'd4, 16'd5};
        btn_toggle = 1'b1; step(); btn_toggle = 1'b0;
        for (int k = 0; k < 12; k++) begin
            btn_lap = (k == 3 || k == 5 || k == 7 || k == 9 || k == 11);
            step();
        end
        btn_lap = 1'b0;
        checks++; if (lap_level !== 3'd4 || lap_overflow !== 1'b1) begin errors++; $display("FAIL fifo_full: got level=%0d ovf=%b expected 4/1", lap_level, lap_overflow); end
        btn_toggle = 1'b1; step(); btn_toggle = 1'b0;
        checks++; if (running !== 1'b0 || count !== 16'd12) begin errors++; $display("FAIL fifo_pause: got running=%b count=%0d expected 0/12", running, count); end
        step();
        checks++; if (lap_valid !== 1'b1 || lap_data !== 16'd3) begin errors++; $display("FAIL head_stable: got valid=%b data=%0d expected 1/3", lap_valid, lap_data); end
        lap_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            checks++; if (lap_valid !== 1'b1 || lap_data !== exp_a[j]) begin errors++; $display("FAIL drain_a%0d: got valid=%b data=%0d expected 1/%0d", j, lap_valid, lap_data, exp_a[j]); end
            step();
        end
        lap_ready = 1'b0;
        checks++; if (lap_valid !== 1'b0 || lap_level !== 3'd0) begin errors++; $display("FAIL drained: got valid=%b level=%0d expected 0/0", lap_valid, lap_level); end

        btn_clear = 1'b1; step(); btn_clear = 1'b0;
        btn_toggle = 1'b1; step(); btn_toggle = 1'b0;
        for (int k = 0; k < 5; k++) begin
            btn_lap = (k >= 1);
            step();
        end
        checks++; if (lap_level !== 3'd4 || lap_overflow !== 1'b0 || lap_data !== 16'd1) begin errors++; $display("FAIL refill: got level=%0d ovf=%b head=%0d expected 4/0/1", lap_level, lap_overflow, lap_data); end
        btn_lap = 1'b1; lap_ready = 1'b1;
        step();
        btn_lap = 1'b0; lap_ready = 1'b0;
        checks++; if (lap_level !== 3'd4 || lap_overflow !== 1'b0 || lap_data !== 16'd2) begin errors++; $display("FAIL push_pop_full: got level=%0d ovf=%b head=%0d expected 4/0/2", lap_level, lap_overflow, lap_data); end
        lap_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            checks++; if (lap_valid !== 1'b1 || lap_data !== exp_b[j]) begin errors++; $display("FAIL drain_b%0d: got valid=%b data=%0d expected 1/%0d", j, lap_valid, lap_data, exp_b[j]); end
            step();
        end
        lap_ready = 1'b0;
    endtask

    task automatic test_lap_idle_toggle();
        btn_clear = 1'b1; step(); btn_clear = 1'b0;
        btn_lap = 1'b1; step(); btn_lap = 1'b0;
        checks++; if (lap_level !== 3'd0 || lap_valid !== 1'b0) begin errors++; $display("FAIL lap_in_idle: got level=%0d valid=%b expected 0/0", lap_level, lap_valid); end
        btn_toggle = 1'b1; step(); btn_toggle = 1'b0;
        repeat (20) step();
        checks++; if (count !== 16'd20) begin errors++; $display("FAIL reach_20: got %0d expected 20", count); end
        btn_lap = 1'b1; btn_toggle = 1'b1;
        step();
        btn_lap = 1'b0; btn_toggle = 1'b0;
        checks++; if (running !== 1'b0 || count !== 16'd20) begin errors++; $display("FAIL lap_toggle_state: got running=%b count=%0d expected 0/20", running, count); end
        checks++; if (lap_level !== 3'd1 || lap_valid !== 1'b1 || lap_data !== 16'd20) begin errors++; $display("FAIL lap_toggle_capture: got level=%0d valid=%b data=%0d expected 1/1/20", lap_level, lap_valid, lap_data); end
        step();
        checks++; if (count !== 16'd20) begin errors++; $display("FAIL paused_20: got %0d expected 20", count); end
    endtask

    task automatic test_async_reset();
        btn_toggle = 1'b1; step(); btn_toggle = 1'b0;
        repeat (17) step();
        checks++; if (count !== 16'd37 || running !== 1'b1) begin errors++; $display("FAIL reach_37: got count=%0d running=%b expected 37/1", count, running); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (count !== 16'd0 || running !== 1'b0) begin errors++; $display("FAIL async_reset_state: got count=%0d running=%b expected 0/0", count, running); end
        checks++; if (lap_level !== 3'd0 || lap_valid !== 1'b0) begin errors++; $display("FAIL async_reset_fifo: got level=%0d valid=%b expected 0/0", lap_level, lap_valid); end
        @(posedge clk); #1;
        reset = 1'b0;
        step();
        checks++; if (count !== 16'd0 || running !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got count=%0d running=%b expected 0/0", count, running); end
    endtask

    initial begin
        test_reset();
        test_run_pause();
        test_wrap();
        test_clear_toggle();
        test_lap_fifo();
        test_lap_idle_toggle();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
